// File: rtl/mac_sequencer.sv
// Feed sequencer for an external 8-bit MAC: it keeps a sample window, coefficients and a bias,
// runs one dot product per accepted sample and returns the MAC result on a valid/ready stream.
module mac_sequencer #(
    parameter int TAPS = 4,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    s_TDATA,
    input  logic          s_TVALID,
    output logic          s_TREADY,
    input  logic          k_wr_en,
    input  logic [AW-1:0] k_wr_addr,
    input  logic [7:0]    k_wr_data,
    input  logic          bias_wr_en,
    input  logic [7:0]    bias_wr_data,
    output logic          cfg_ready,
    output logic [7:0]    i_TDATA,
    output logic [7:0]    k_TDATA,
    output logic [7:0]    b_TDATA,
    output logic          r_enable,
    output logic          a_enable,
    output logic          b_enable,
    input  logic [7:0]    mac_TDATA,
    output logic [7:0]    m_TDATA,
    output logic          m_TVALID,
    input  logic          m_TREADY
);
    typedef enum logic [2:0] {IDLE, MUL, DRAIN, WAIT, OUT} state_t;

    state_t        state, state_next;
    logic [7:0]    win  [TAPS];
    logic [7:0]    coef [TAPS];
    logic [7:0]    bias;
    logic [AW-1:0] idx;
    logic [7:0]    m_data_q;
    logic          m_valid_q;
    logic          last_tap;

    // Held low while reset is asserted so nothing is accepted before IDLE is established.
    assign cfg_ready = (state == IDLE) && !reset;
    assign s_TREADY  = cfg_ready;
    assign last_tap  = (idx == AW'(TAPS - 1));
    assign b_TDATA   = bias;
    assign m_TDATA   = m_data_q;
    assign m_TVALID  = m_valid_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        i_TDATA    = '0;
        k_TDATA    = '0;
        r_enable   = 1'b0;
        a_enable   = 1'b0;
        b_enable   = 1'b0;
        case (state)
            IDLE:  if (s_TVALID) state_next = MUL;
            MUL: begin
                i_TDATA  = win[idx];
                k_TDATA  = coef[idx];
                r_enable = 1'b1;
                // Product register lags by one cycle: tap 0's product is summed with the bias at tap 1.
                a_enable = (idx != '0);
                b_enable = (idx == AW'(1));
                if (last_tap) state_next = DRAIN;
            end
            DRAIN: begin
                a_enable   = 1'b1;
                state_next = WAIT;
            end
            WAIT:  state_next = OUT;
            OUT:   if (m_TREADY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the window and coefficient arrays are explicitly cleared on reset; results depend on it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                win[i]  <= '0;
                coef[i] <= '0;
            end
            bias      <= '0;
            idx       <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            if (cfg_ready) begin
                // Address decode by match leaves indices >= TAPS with no target.
                if (k_wr_en) begin
                    for (int i = 0; i < TAPS; i++) begin
                        if (k_wr_addr == AW'(i)) coef[i] <= k_wr_data;
                    end
                end
                if (bias_wr_en) bias <= bias_wr_data;
            end
            case (state)
                IDLE: begin
                    if (s_TVALID) begin
                        win[0] <= s_TDATA;
                        for (int i = 1; i < TAPS; i++) win[i] <= win[i-1];
                        idx <= '0;
                    end
                end
                MUL:  if (!last_tap) idx <= idx + AW'(1);
                WAIT: begin
                    m_data_q  <= mac_TDATA;
                    m_valid_q <= 1'b1;
                end
                OUT:  if (m_TREADY) m_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
